// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions, FSM encodings and divider helper
// for the memory-mapped UART.
package uart_pkg;

   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_TX_DATA = 3'd1;
   localparam logic [2:0] REG_RX_DATA = 3'd2;
   localparam logic [2:0] REG_RX_POP  = 3'd3;
   localparam logic [2:0] REG_DIVIDER = 3'd4;

   localparam int unsigned ST_RX_VALID    = 0;
   localparam int unsigned ST_TX_FULL     = 1;
   localparam int unsigned ST_TX_IDLE     = 2;
   localparam int unsigned ST_RX_OVERRUN  = 3;
   localparam int unsigned ST_FRAMING_ERR = 4;
   localparam int unsigned ST_TX_OVERFLOW = 5;

   localparam logic [15:0] MIN_DIVIDER = 16'd4;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   function automatic logic [15:0] clamp_divider(input logic [15:0] d);
      return (d < MIN_DIVIDER) ? MIN_DIVIDER : d;
   endfunction

endpackage

// File: rtl/uart_device_fifo.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_device.sv
// Memory-mapped 8N1 UART: STATUS/TX_DATA/RX_DATA/RX_POP/DIVIDER registers,
// TX and RX byte FIFOs, programmable baud divider latched per frame.
module uart_device
   import uart_pkg::*;
#(
   parameter int unsigned CLOCKS_PER_BIT = 104,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        write_enable,
   input  logic [15:0] address,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        rx,
   output logic        tx
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [2:0]    reg_sel;
   logic          unused_address;
   logic [15:0]   divider;
   logic [15:0]   status;

   logic          tx_push, tx_full, tx_empty;
   logic [7:0]    tx_fifo_dout;
   logic [CW-1:0] tx_count;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    rx_fifo_dout;
   logic [CW-1:0] rx_count;

   logic          status_wr;
   logic          rx_overrun, framing_error, tx_overflow;

   tx_state_t     tx_state, tx_next;
   logic [15:0]   tx_div, tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_pop, tx_bit_end;

   rx_state_t     rx_state, rx_next;
   logic [1:0]    rx_sync;
   logic          rx_s, rx_prev;
   logic [15:0]   rx_div, rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_bit_end, rx_half_end, rx_sample, rx_frame_err;

   assign reg_sel        = address[2:0];
   assign unused_address = ^address[15:3];
   assign status_wr      = write_enable && (reg_sel == REG_STATUS);
   assign tx_push        = write_enable && (reg_sel == REG_TX_DATA);
   assign rx_pop         = write_enable && (reg_sel == REG_RX_POP);

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (data_in[7:0]),
      .dout  (tx_fifo_dout),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_shift),
      .dout  (rx_fifo_dout),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         divider <= 16'(CLOCKS_PER_BIT);
      end else if (write_enable && (reg_sel == REG_DIVIDER)) begin
         divider <= data_in;
      end
   end

   // ---------------- transmitter ----------------
   always_comb begin
      tx_next    = tx_state;
      tx_pop     = 1'b0;
      tx_bit_end = (tx_cnt == tx_div - 16'd1);
      case (tx_state)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_next = TX_START;
               tx_pop  = 1'b1;
            end
         end
         TX_START: if (tx_bit_end) tx_next = TX_DATA;
         TX_DATA:  if (tx_bit_end && (tx_bit == 3'd7)) tx_next = TX_STOP;
         TX_STOP: begin
            if (tx_bit_end) begin
               // chain straight into the next frame so there is no idle gap
               if (!tx_empty) begin
                  tx_next = TX_START;
                  tx_pop  = 1'b1;
               end else begin
                  tx_next = TX_IDLE;
               end
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '1;
         tx_div   <= clamp_divider(16'(CLOCKS_PER_BIT));
      end else begin
         tx_state <= tx_next;
         if (tx_pop) begin
            tx_shift <= tx_fifo_dout;
            tx_div   <= clamp_divider(divider);
            tx_cnt   <= '0;
            tx_bit   <= '0;
         end else if (tx_state == TX_IDLE) begin
            tx_cnt <= '0;
         end else if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_state == TX_DATA) begin
               tx_shift <= {1'b1, tx_shift[7:1]};
               tx_bit   <= tx_bit + 3'd1;
            end
         end else begin
            tx_cnt <= tx_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      case (tx_state)
         TX_START: tx = 1'b0;
         TX_DATA:  tx = tx_shift[0];
         default:  tx = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_sync <= '1;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], rx};
         rx_prev <= rx_sync[1];
      end
   end

   assign rx_s = rx_sync[1];

   always_comb begin
      rx_next      = rx_state;
      rx_sample    = 1'b0;
      rx_push      = 1'b0;
      rx_frame_err = 1'b0;
      rx_bit_end   = (rx_cnt == rx_div - 16'd1);
      rx_half_end  = (rx_cnt == (rx_div >> 1) - 16'd1);
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
         RX_START: if (rx_half_end) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_sample = 1'b1;
               if (rx_bit == 3'd7) rx_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_bit_end) begin
               rx_next      = RX_IDLE;
               rx_push      = rx_s;
               rx_frame_err = !rx_s;
            end
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // counter restarts at mid start bit so later samples land mid-bit
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_div   <= clamp_divider(16'(CLOCKS_PER_BIT));
      end else begin
         rx_state <= rx_next;
         if (rx_state == RX_IDLE) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            if (rx_next == RX_START) rx_div <= clamp_divider(divider);
         end else if (((rx_state == RX_START) && rx_half_end) || rx_bit_end) begin
            rx_cnt <= '0;
            if (rx_sample) begin
               rx_shift <= {rx_s, rx_shift[7:1]};
               rx_bit   <= rx_bit + 3'd1;
            end
         end else begin
            rx_cnt <= rx_cnt + 16'd1;
         end
      end
   end

   // ---------------- status and read port ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_overrun    <= 1'b0;
         framing_error <= 1'b0;
         tx_overflow   <= 1'b0;
      end else begin
         rx_overrun    <= (rx_overrun & ~(status_wr & data_in[ST_RX_OVERRUN]))
                          | (rx_push & rx_full & ~rx_pop);
         framing_error <= (framing_error & ~(status_wr & data_in[ST_FRAMING_ERR]))
                          | rx_frame_err;
         tx_overflow   <= (tx_overflow & ~(status_wr & data_in[ST_TX_OVERFLOW]))
                          | (tx_push & tx_full & ~tx_pop);
      end
   end

   always_comb begin
      status                 = '0;
      status[ST_RX_VALID]    = !rx_empty;
      status[ST_TX_FULL]     = tx_full;
      status[ST_TX_IDLE]     = tx_empty && (tx_state == TX_IDLE);
      status[ST_RX_OVERRUN]  = rx_overrun;
      status[ST_FRAMING_ERR] = framing_error;
      status[ST_TX_OVERFLOW] = tx_overflow;
      status[11:8]           = 4'(rx_count);
      status[15:12]          = 4'(tx_count);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out <= '0;
      end else begin
         case (reg_sel)
            REG_STATUS:  data_out <= status;
            REG_RX_DATA: data_out <= rx_empty ? 16'h0000 : {8'h00, rx_fifo_dout};
            REG_DIVIDER: data_out <= divider;
            default:     data_out <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_device.sv
// Directed self-checking bench for uart_device with a 4-clock bit period.
module tb_uart_device;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        write_enable = 1'b0;
   logic [15:0] address = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        rx = 1'b1;
   logic        tx;

   int tests_run = 0;
   int tests_failed = 0;

   uart_device #(.CLOCKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .write_enable (write_enable),
      .address      (address),
      .data_in      (data_in),
      .data_out     (data_out),
      .rx           (rx),
      .tx           (tx)
   );

   always #5 clock = ~clock;

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clock);
      write_enable = 1'b1;
      address      = a;
      data_in      = d;
      @(negedge clock);
      write_enable = 1'b0;
      address      = '0;
      data_in      = '0;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
      @(negedge clock);
      write_enable = 1'b0;
      address      = a;
      @(negedge clock);
      d = data_out;
   endtask

   task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (4) @(negedge clock);
      end
      rx = 1'b1;
      repeat (8) @(negedge clock);
   endtask

   // steps negedges until tx is low; returns the number of steps taken
   task automatic wait_tx_low(output int n);
      n = 0;
      while (tx !== 1'b0 && n < 40) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic test_reset;
      logic [15:0] rd;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      tests_run++;
      if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", tx); end
      tests_run++;
      if (data_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
      reset = 1'b0;
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL reset_status: got %h expected 0004", rd); end
      cpu_read(16'd4, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL reset_divider: got %h expected 0004", rd); end
      cpu_read(16'd2, rd);
      tests_run++;
      if (rd !== 16'h0000) begin tests_failed++; $display("FAIL reset_rx_data: got %h expected 0000", rd); end
      cpu_write(16'd5, 16'hFFFF);
      cpu_read(16'd5, rd);
      tests_run++;
      if (rd !== 16'h0000) begin tests_failed++; $display("FAIL unmapped_read: got %h expected 0000", rd); end
   endtask

   task automatic test_tx_frame;
      logic [9:0]  f;
      logic [15:0] rd;
      int          n;
      f = {1'b1, 8'hA5, 1'b0};
      cpu_write(16'd1, 16'h00A5);
      wait_tx_low(n);
      tests_run++;
      if (n != 1) begin tests_failed++; $display("FAIL tx_start_latency: got %0d expected 1", n); end
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clock);
         tests_run++;
         if (tx !== f[i/4]) begin
            tests_failed++;
            $display("FAIL tx_frame_bit%0d_clk%0d: got %b expected %b", i/4, i%4, tx, f[i/4]);
         end
      end
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL tx_idle_status: got %h expected 0004", rd); end
   endtask

   task automatic test_back_to_back;
      logic [19:0] f;
      int          n;
      f = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
      @(negedge clock);
      write_enable = 1'b1;
      address      = 16'd1;
      data_in      = 16'h00A5;
      @(negedge clock);
      data_in      = 16'h003C;
      @(negedge clock);
      write_enable = 1'b0;
      wait_tx_low(n);
      tests_run++;
      if (tx !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_start: got %b expected 0", tx);
      end else begin
         for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge clock);
            tests_run++;
            if (tx !== f[i/4]) begin
               tests_failed++;
               $display("FAIL b2b_bit%0d_clk%0d: got %b expected %b", i/4, i%4, tx, f[i/4]);
            end
         end
      end
      repeat (8) @(negedge clock);
   endtask

   task automatic test_divider;
      logic [15:0] rd;
      int          n;
      int          len;
      cpu_write(16'd4, 16'h0002);
      cpu_read(16'd4, rd);
      tests_run++;
      if (rd !== 16'h0002) begin tests_failed++; $display("FAIL divider_readback: got %h expected 0002", rd); end
      cpu_write(16'd1, 16'h0001);
      wait_tx_low(n);
      len = 0;
      while (tx === 1'b0 && len < 50) begin len++; @(negedge clock); end
      tests_run++;
      if (len != 4) begin tests_failed++; $display("FAIL divider_clamp_start_len: got %0d expected 4", len); end
      repeat (60) @(negedge clock);
      cpu_write(16'd4, 16'h0008);
      cpu_write(16'd1, 16'h0001);
      wait_tx_low(n);
      len = 0;
      while (tx === 1'b0 && len < 50) begin len++; @(negedge clock); end
      tests_run++;
      if (len != 8) begin tests_failed++; $display("FAIL divider8_start_len: got %0d expected 8", len); end
      repeat (100) @(negedge clock);
      cpu_write(16'd4, 16'h0004);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL divider_idle_status: got %h expected 0004", rd); end
   endtask

   task automatic test_rx_frame;
      logic [15:0] rd;
      send_rx_frame(8'h3C, 1'b1);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0105) begin tests_failed++; $display("FAIL rx_status: got %h expected 0105", rd); end
      cpu_read(16'd2, rd);
      tests_run++;
      if (rd !== 16'h003C) begin tests_failed++; $display("FAIL rx_data: got %h expected 003C", rd); end
      cpu_read(16'd2, rd);
      tests_run++;
      if (rd !== 16'h003C) begin tests_failed++; $display("FAIL rx_data_reread: got %h expected 003C", rd); end
      cpu_write(16'd3, 16'h0000);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL rx_after_pop: got %h expected 0004", rd); end
      cpu_write(16'd3, 16'h0000);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL rx_pop_empty: got %h expected 0004", rd); end
   endtask

   task automatic test_rx_errors;
      logic [15:0] rd;
      @(negedge clock);
      rx = 1'b0;
      @(negedge clock);
      rx = 1'b1;
      repeat (12) @(negedge clock);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL rx_glitch: got %h expected 0004", rd); end
      send_rx_frame(8'h55, 1'b0);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0014) begin tests_failed++; $display("FAIL rx_framing: got %h expected 0014", rd); end
      cpu_write(16'd0, 16'h0010);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL rx_framing_clear: got %h expected 0004", rd); end
   endtask

   task automatic test_rx_overrun;
      logic [15:0] rd;
      logic [7:0]  b;
      for (int i = 0; i < 9; i++) begin
         b = 8'h40 + 8'(i);
         send_rx_frame(b, 1'b1);
      end
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h080D) begin tests_failed++; $display("FAIL rx_overrun_status: got %h expected 080D", rd); end
      cpu_write(16'd0, 16'h0008);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0805) begin tests_failed++; $display("FAIL rx_overrun_clear: got %h expected 0805", rd); end
      for (int i = 0; i < 8; i++) begin
         cpu_read(16'd2, rd);
         tests_run++;
         if (rd !== (16'h0040 + 16'(i))) begin
            tests_failed++;
            $display("FAIL rx_fifo_order%0d: got %h expected %h", i, rd, 16'h0040 + 16'(i));
         end
         cpu_write(16'd3, 16'h0000);
      end
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL rx_drained: got %h expected 0004", rd); end
   endtask

   task automatic test_tx_overflow;
      logic [15:0] rd;
      int          n;
      cpu_write(16'd1, 16'h0000);
      wait_tx_low(n);
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         write_enable = 1'b1;
         address      = 16'd1;
         data_in      = 16'h0010 + 16'(i);
      end
      @(negedge clock);
      write_enable = 1'b0;
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h8022) begin tests_failed++; $display("FAIL tx_overflow_status: got %h expected 8022", rd); end
      cpu_write(16'd0, 16'h0020);
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h8002) begin tests_failed++; $display("FAIL tx_overflow_clear: got %h expected 8002", rd); end
      n = 0;
      rd = '0;
      while (rd[2] !== 1'b1 && n < 400) begin
         cpu_read(16'd0, rd);
         n++;
      end
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL tx_drain_idle: got %h expected 0004", rd); end
   endtask

   task automatic test_reset_mid_tx;
      logic [15:0] rd;
      int          n;
      cpu_write(16'd1, 16'h00A5);
      cpu_write(16'd4, 16'h0007);
      wait_tx_low(n);
      @(negedge clock);
      tests_run++;
      if (tx !== 1'b0) begin tests_failed++; $display("FAIL pre_reset_tx: got %b expected 0", tx); end
      reset = 1'b1;
      @(negedge clock);
      tests_run++;
      if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_tx: got %b expected 1", tx); end
      @(negedge clock);
      reset = 1'b0;
      cpu_read(16'd0, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL reset_mid_status: got %h expected 0004", rd); end
      cpu_read(16'd4, rd);
      tests_run++;
      if (rd !== 16'h0004) begin tests_failed++; $display("FAIL reset_mid_divider: got %h expected 0004", rd); end
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_back_to_back();
      test_divider();
      test_rx_frame();
      test_rx_errors();
      test_rx_overrun();
      test_tx_overflow();
      test_reset_mid_tx();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
